// File: rtl/store_retire_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_retire_buffer
// Brief    : In-order store buffer. Entries are allocated at dispatch, filled
//            from the CDB and retired as a registered one-cycle memory write.
// Revision : 1.0 - initial release
// ============================================================================
module store_retire_buffer #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [TAG_W-1:0]  alloc_tag,
  output logic              alloc_ready,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_result,
  input  logic [DATA_W-1:0] cdb_store_data,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  output logic              commit_ack,
  output logic              store_ready,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] retire_rs2_data,
  output logic              empty
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full    = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_filled;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_ptr_w:0]   r_count;

  logic             w_alloc;
  logic [DEPTH-1:0] w_capture;

  assign alloc_ready = (r_count != c_full);
  assign empty       = (r_count == '0);
  assign w_alloc     = alloc_valid && alloc_ready && !flush;

  // Commit needs the head already filled, so a same-cycle capture never retires.
  assign commit_ack = commit_valid && r_valid[r_head] && r_filled[r_head] &&
                      (r_tag[r_head] == commit_tag) && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_capture
    assign w_capture[i] = cdb_valid && r_valid[i] && !r_filled[i] &&
                          (r_tag[i] == cdb_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_valid  <= '0;
      r_filled <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_capture[i]) begin
          r_filled[i] <= 1'b1;
          r_addr[i]   <= cdb_result;
          r_data[i]   <= cdb_store_data;
        end
      end
      if (commit_ack) begin
        r_valid[r_head]  <= 1'b0;
        r_filled[r_head] <= 1'b0;
      end
      // Tail slot is never live here, so this cannot collide with capture/commit.
      if (w_alloc) begin
        r_valid[r_tail]  <= 1'b1;
        r_filled[r_tail] <= 1'b0;
        r_tag[r_tail]    <= alloc_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (commit_ack) begin
        r_head <= r_head + c_ptr_one;
      end
      if (w_alloc) begin
        r_tail <= r_tail + c_ptr_one;
      end
      case ({w_alloc, commit_ack})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // A flush leaves the write already registered for this cycle untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_ready     <= 1'b0;
      mem_address     <= '0;
      retire_rs2_data <= '0;
    end else begin
      store_ready <= commit_ack;
      if (commit_ack) begin
        mem_address     <= r_addr[r_head];
        retire_rs2_data <= r_data[r_head];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_retire_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_retire_buffer
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_retire_buffer;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              alloc_valid;
  logic [TAG_W-1:0]  alloc_tag;
  logic              alloc_ready;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_result;
  logic [DATA_W-1:0] cdb_store_data;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic              commit_ack;
  logic              store_ready;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] retire_rs2_data;
  logic              empty;

  store_retire_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_ready(alloc_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .cdb_store_data(cdb_store_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_ack(commit_ack),
    .store_ready(store_ready), .mem_address(mem_address),
    .retire_rs2_data(retire_rs2_data), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program-order model: queue front is the oldest live store.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              filled;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t mq[$];
  logic [DATA_W-1:0] obs_ret[$];

  int checks   = 0;
  int failures = 0;

  logic              exp_ack, exp_alloc_ready, exp_empty, exp_sr;
  logic [DATA_W-1:0] exp_ma, exp_rd;
  logic              obs_ack, obs_alloc_ready, obs_empty, obs_sr;
  logic [DATA_W-1:0] obs_ma, obs_rd;

  task automatic set_idle();
    flush = 0; alloc_valid = 0; alloc_tag = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_result = '0; cdb_store_data = '0;
    commit_valid = 0; commit_tag = '0;
  endtask

  // One clock: sample combinational outputs mid-cycle, advance the model at the
  // edge, then sample registered outputs just after it.
  task automatic tick();
    logic do_alloc;
    @(negedge clk);
    obs_ack = commit_ack; obs_alloc_ready = alloc_ready; obs_empty = empty;
    exp_alloc_ready = (mq.size() != DEPTH);
    exp_empty       = (mq.size() == 0);
    exp_ack = commit_valid && !flush && (mq.size() > 0) &&
              mq[0].filled && (mq[0].tag == commit_tag);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_sr = 0; exp_ma = '0; exp_rd = '0;
    end else begin
      exp_sr = exp_ack;
      if (exp_ack) begin
        exp_ma = mq[0].addr;
        exp_rd = mq[0].data;
      end
      if (flush) begin
        mq.delete();
      end else begin
        do_alloc = alloc_valid && (mq.size() != DEPTH);
        if (cdb_valid)
          for (int i = 0; i < mq.size(); i++)
            if (!mq[i].filled && mq[i].tag == cdb_tag) begin
              mq[i].filled = 1'b1;
              mq[i].addr   = cdb_result;
              mq[i].data   = cdb_store_data;
            end
        if (exp_ack) void'(mq.pop_front());
        if (do_alloc) mq.push_back('{tag: alloc_tag, filled: 1'b0, addr: '0, data: '0});
      end
    end
    #1;
    obs_sr = store_ready; obs_ma = mem_address; obs_rd = retire_rs2_data;
    if (obs_sr === 1'b1) obs_ret.push_back(obs_ma);
  endtask

  task automatic do_alloc_tick(input logic [TAG_W-1:0] t);
    set_idle(); alloc_valid = 1; alloc_tag = t; tick();
  endtask

  task automatic do_fill_tick(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    set_idle(); cdb_valid = 1; cdb_tag = t; cdb_result = a; cdb_store_data = d; tick();
  endtask

  task automatic test_reset();
    rst = 1; set_idle(); commit_valid = 1; commit_tag = '0;
    tick(); tick();
    checks++; if (obs_sr !== 1'b0) begin failures++; $display("FAIL reset_store_ready got=%b exp=0", obs_sr); end
    checks++; if (obs_ma !== '0) begin failures++; $display("FAIL reset_mem_address got=%h exp=0", obs_ma); end
    checks++; if (obs_rd !== '0) begin failures++; $display("FAIL reset_rs2_data got=%h exp=0", obs_rd); end
    checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL reset_commit_ack got=%b exp=0", obs_ack); end
    rst = 0; set_idle(); tick();
    checks++; if (obs_alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%b exp=1", obs_alloc_ready); end
    checks++; if (obs_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", obs_empty); end
  endtask

  task automatic test_basic();
    do_alloc_tick(6'd5);
    checks++; if (obs_alloc_ready !== 1'b1) begin failures++; $display("FAIL basic_alloc_ready got=%b exp=1", obs_alloc_ready); end
    set_idle(); cdb_valid = 1; cdb_tag = 6'd5; cdb_result = 32'h10; cdb_store_data = 32'hAB;
    commit_valid = 1; commit_tag = 6'd5; tick();
    checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_same_cycle_as_cdb got=%b exp=0", obs_ack); end
    set_idle(); commit_valid = 1; commit_tag = 6'd5; tick();
    checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL basic_ack got=%b exp=1", obs_ack); end
    checks++; if (obs_sr !== 1'b1 || obs_ma !== 32'h10 || obs_rd !== 32'hAB) begin
      failures++; $display("FAIL basic_write got=%b/%h/%h exp=1/10/ab", obs_sr, obs_ma, obs_rd); end
    set_idle(); tick();
    checks++; if (obs_sr !== 1'b0) begin failures++; $display("FAIL basic_strobe_drop got=%b exp=0", obs_sr); end
    checks++; if (obs_empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", obs_empty); end
  endtask

  task automatic test_full_order();
    // Per row: cdb_valid, cdb_tag, commit_valid, commit_tag, expected ack
    logic [15:0] rows [12] = '{
      {1'b1, 6'd3, 1'b0, 6'd0, 2'd0}, {1'b1, 6'd1, 1'b1, 6'd2, 2'd0},
      {1'b0, 6'd0, 1'b1, 6'd1, 2'd1}, {1'b0, 6'd0, 1'b1, 6'd2, 2'd0},
      {1'b0, 6'd0, 1'b1, 6'd2, 2'd0}, {1'b1, 6'd2, 1'b1, 6'd2, 2'd0},
      {1'b0, 6'd0, 1'b1, 6'd2, 2'd1}, {1'b0, 6'd0, 1'b1, 6'd3, 2'd1},
      {1'b0, 6'd0, 1'b1, 6'd4, 2'd0}, {1'b1, 6'd4, 1'b1, 6'd4, 2'd0},
      {1'b0, 6'd0, 1'b1, 6'd4, 2'd1}, {1'b0, 6'd0, 1'b0, 6'd0, 2'd0}};
    obs_ret.delete();
    for (int t = 1; t <= 4; t++) begin
      do_alloc_tick(TAG_W'(t));
      checks++; if (obs_alloc_ready !== 1'b1) begin failures++; $display("FAIL full_alloc_ready_%0d got=%b exp=1", t, obs_alloc_ready); end
    end
    do_alloc_tick(6'd9);
    checks++; if (obs_alloc_ready !== 1'b0) begin failures++; $display("FAIL full_alloc_ready got=%b exp=0", obs_alloc_ready); end
    for (int r = 0; r < 12; r++) begin
      logic [15:0] row;
      row = rows[r];
      set_idle();
      cdb_valid = row[15]; cdb_tag = row[14:9];
      cdb_result = {24'h0, 2'b0, row[14:9]} << 8; cdb_store_data = {26'h0, row[14:9]};
      commit_valid = row[8]; commit_tag = row[7:2];
      tick();
      checks++; if (obs_ack !== row[0]) begin failures++; $display("FAIL full_order_ack_row%0d got=%b exp=%b", r, obs_ack, row[0]); end
    end
    set_idle(); tick();
    checks++; if (obs_ret.size() != 4) begin failures++; $display("FAIL full_order_count got=%0d exp=4", obs_ret.size()); end
    for (int i = 0; i < obs_ret.size() && i < 4; i++) begin
      checks++; if (obs_ret[i] !== 32'((i + 1) << 8)) begin
        failures++; $display("FAIL full_order_addr%0d got=%h exp=%h", i, obs_ret[i], 32'((i + 1) << 8)); end
    end
    checks++; if (obs_empty !== 1'b1) begin failures++; $display("FAIL full_drained_empty got=%b exp=1", obs_empty); end
  endtask

  task automatic test_wrong_tag();
    do_alloc_tick(6'd6);
    do_fill_tick(6'd6, 32'h60, 32'h66);
    for (int k = 0; k < 2; k++) begin
      set_idle(); commit_valid = 1; commit_tag = 6'd7; tick();
      checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL wrong_tag_ack got=%b exp=0", obs_ack); end
      checks++; if (obs_sr !== 1'b0) begin failures++; $display("FAIL wrong_tag_write got=%b exp=0", obs_sr); end
    end
    set_idle(); commit_valid = 1; commit_tag = 6'd6; tick();
    checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL wrong_tag_retry_ack got=%b exp=1", obs_ack); end
    set_idle(); tick();
  endtask

  task automatic test_flush_after_commit();
    do_alloc_tick(6'd20);
    do_alloc_tick(6'd21);
    do_fill_tick(6'd20, 32'h200, 32'hA0);
    do_fill_tick(6'd21, 32'h210, 32'hA1);
    set_idle(); commit_valid = 1; commit_tag = 6'd20; tick();
    checks++; if (obs_ack !== 1'b1) begin failures++; $display("FAIL flush_first_ack got=%b exp=1", obs_ack); end
    set_idle(); flush = 1; commit_valid = 1; commit_tag = 6'd21; alloc_valid = 1; alloc_tag = 6'd22;
    checks++; if (obs_sr !== 1'b1 || obs_ma !== 32'h200 || obs_rd !== 32'hA0) begin
      failures++; $display("FAIL flush_committed_write got=%b/%h/%h exp=1/200/a0", obs_sr, obs_ma, obs_rd); end
    tick();
    checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL flush_wins_ack got=%b exp=0", obs_ack); end
    set_idle(); tick();
    checks++; if (obs_empty !== 1'b1 || obs_alloc_ready !== 1'b1) begin
      failures++; $display("FAIL flush_empty got=%b/%b exp=1/1", obs_empty, obs_alloc_ready); end
    set_idle(); commit_valid = 1; commit_tag = 6'd21; tick();
    checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL flush_second_ack got=%b exp=0", obs_ack); end
    set_idle(); tick();
    checks++; if (obs_sr !== 1'b0) begin failures++; $display("FAIL flush_second_write got=%b exp=0", obs_sr); end
  endtask

  task automatic test_back_to_back();
    do_alloc_tick(6'd30);
    do_alloc_tick(6'd31);
    do_fill_tick(6'd30, 32'h300, 32'hB0);
    do_fill_tick(6'd31, 32'h310, 32'hB1);
    for (int k = 0; k < 2; k++) begin
      set_idle(); commit_valid = 1; commit_tag = TAG_W'(30 + k); tick();
      checks++; if (obs_ack !== 1'b1 || obs_sr !== 1'b1 || obs_ma !== 32'(32'h300 + 16 * k)) begin
        failures++; $display("FAIL b2b_commit%0d got=%b/%b/%h exp=1/1/%h", k, obs_ack, obs_sr, obs_ma, 32'(32'h300 + 16 * k)); end
    end
    set_idle(); tick();
    checks++; if (obs_sr !== 1'b0) begin failures++; $display("FAIL b2b_strobe_drop got=%b exp=0", obs_sr); end
  endtask

  task automatic test_wrap();
    obs_ret.delete();
    for (int t = 0; t < 10; t++) begin
      do_alloc_tick(TAG_W'(t));
      do_fill_tick(TAG_W'(t), 32'(4 * t), 32'(t) ^ 32'h5A5A);
      set_idle(); commit_valid = 1; commit_tag = TAG_W'(t); tick();
      checks++; if (obs_ack !== 1'b1 || obs_rd !== (32'(t) ^ 32'h5A5A)) begin
        failures++; $display("FAIL wrap_commit%0d got=%b/%h exp=1/%h", t, obs_ack, obs_rd, 32'(t) ^ 32'h5A5A); end
    end
    set_idle(); tick();
    checks++; if (obs_ret.size() != 10) begin failures++; $display("FAIL wrap_count got=%0d exp=10", obs_ret.size()); end
    for (int i = 0; i < obs_ret.size() && i < 10; i++) begin
      checks++; if (obs_ret[i] !== 32'(4 * i)) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, obs_ret[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_load_ignore();
    do_fill_tick(6'd12, 32'hDEAD, 32'hBEEF);
    set_idle(); commit_valid = 1; commit_tag = 6'd12; tick();
    checks++; if (obs_empty !== 1'b1) begin failures++; $display("FAIL load_empty got=%b exp=1", obs_empty); end
    checks++; if (obs_ack !== 1'b0) begin failures++; $display("FAIL load_ack got=%b exp=0", obs_ack); end
    set_idle(); tick();
  endtask

  task automatic test_random();
    logic [TAG_W-1:0] next_tag;
    next_tag = 6'd40;
    for (int c = 0; c < 800; c++) begin
      set_idle();
      rst   = ($urandom_range(99) == 0);
      flush = ($urandom_range(39) == 0);
      if ($urandom_range(99) < 45) begin
        alloc_valid = 1; alloc_tag = next_tag; next_tag = next_tag + 6'd1;
      end
      if ($urandom_range(99) < 60) begin
        cdb_valid = 1;
        cdb_tag = (mq.size() > 0 && $urandom_range(3) != 0) ? mq[$urandom_range(mq.size() - 1)].tag
                                                              : TAG_W'($urandom);
        cdb_result = $urandom; cdb_store_data = $urandom;
      end
      if ($urandom_range(99) < 70) begin
        commit_valid = 1;
        commit_tag = (mq.size() > 0 && $urandom_range(4) != 0) ? mq[0].tag : TAG_W'($urandom);
      end
      tick();
      checks++; if (obs_ack !== exp_ack || obs_alloc_ready !== exp_alloc_ready || obs_empty !== exp_empty) begin
        failures++; $display("FAIL rand_comb_c%0d ack/ready/empty got=%b%b%b exp=%b%b%b", c,
                             obs_ack, obs_alloc_ready, obs_empty, exp_ack, exp_alloc_ready, exp_empty); end
      checks++; if (obs_sr !== exp_sr || obs_ma !== exp_ma || obs_rd !== exp_rd) begin
        failures++; $display("FAIL rand_write_c%0d got=%b/%h/%h exp=%b/%h/%h", c,
                             obs_sr, obs_ma, obs_rd, exp_sr, exp_ma, exp_rd); end
    end
    rst = 0; set_idle(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; set_idle();
    test_reset();
    test_basic();
    test_full_order();
    test_wrong_tag();
    test_flush_after_commit();
    test_back_to_back();
    test_wrap();
    test_load_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
